// File: rtl/button_debouncer_if.sv
// ============================================================================
// Module      : button_debouncer_if
// Description : Button bundle between the raw devboard buttons, the
//               debouncer and the core's MMIO input port.
//               BUTTON_DEBOUNCER_PRESS_LATCH_EN adds clearLatch/pressLatched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface button_debouncer_if #(
   parameter int NUM_INPUTS = 4
);
   logic [NUM_INPUTS-1:0] rawButton;
   logic [NUM_INPUTS-1:0] debounced;
   logic [NUM_INPUTS-1:0] pressPulse;
   logic [NUM_INPUTS-1:0] releasePulse;
`ifdef BUTTON_DEBOUNCER_PRESS_LATCH_EN
   logic [NUM_INPUTS-1:0] clearLatch;
   logic [NUM_INPUTS-1:0] pressLatched;

   // Side that drives the raw buttons and consumes the clean levels
   modport master (
      output rawButton, clearLatch,
      input  debounced, pressPulse, releasePulse, pressLatched
   );

   // Debouncer side
   modport slave (
      input  rawButton, clearLatch,
      output debounced, pressPulse, releasePulse, pressLatched
   );
`else
   // Side that drives the raw buttons and consumes the clean levels
   modport master (
      output rawButton,
      input  debounced, pressPulse, releasePulse
   );

   // Debouncer side
   modport slave (
      input  rawButton,
      output debounced, pressPulse, releasePulse
   );
`endif
endinterface

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// Module      : button_debouncer
// Description : Per-channel two-flop synchroniser, stability-counter
//               debouncer and registered press/release pulse generator.
//               Optional macro BUTTON_DEBOUNCER_PRESS_LATCH_EN adds a
//               sticky press latch cleared by clearLatch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer #(
   parameter int NUM_INPUTS      = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int COUNTER_WIDTH   = $clog2(DEBOUNCE_CYCLES)
) (
   input  wire logic          clock,
   input  wire logic          notReset,
   button_debouncer_if.slave  bus
);

   typedef enum logic [0:0] {
      STABLE = 1'b0,
      VERIFY = 1'b1
   } state_t;

   // Terminal count: the level has agreed for DEBOUNCE_CYCLES cycles
   localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [NUM_INPUTS-1:0]    sync1_q, sync2_q;
   state_t                   state_q [NUM_INPUTS];
   state_t                   state_d [NUM_INPUTS];
   logic [COUNTER_WIDTH-1:0] count_q [NUM_INPUTS];
   logic [COUNTER_WIDTH-1:0] count_d [NUM_INPUTS];
   logic [NUM_INPUTS-1:0]    debounced_q, debounced_d;
   logic [NUM_INPUTS-1:0]    press_q, press_d;
   logic [NUM_INPUTS-1:0]    release_q, release_d;

   // Two-flop synchroniser for the asynchronous raw buttons
   always_ff @(posedge clock or negedge notReset) begin
      if (!notReset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= bus.rawButton;
         sync2_q <= sync1_q;
      end
   end

   // Per-channel debounce FSM: next state, counter, level and pulses
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      debounced_d = debounced_q;
      press_d     = '0;
      release_d   = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         case (state_q[i])
            STABLE: begin
               count_d[i] = '0;
               if (sync2_q[i] != debounced_q[i]) begin
                  count_d[i] = COUNTER_WIDTH'(1);
                  state_d[i] = VERIFY;
               end
            end
            VERIFY: begin
               if (sync2_q[i] == debounced_q[i]) begin
                  // Bounced back before acceptance: drop all progress
                  count_d[i] = '0;
                  state_d[i] = STABLE;
               end else if (count_q[i] == CNT_MAX) begin
                  debounced_d[i] = sync2_q[i];
                  press_d[i]     = sync2_q[i];
                  release_d[i]   = ~sync2_q[i];
                  count_d[i]     = '0;
                  state_d[i]     = STABLE;
               end else begin
                  count_d[i] = count_q[i] + 1'b1;
               end
            end
            default: begin
               count_d[i] = '0;
               state_d[i] = STABLE;
            end
         endcase
      end
   end

   // FSM state, counters, debounced level and pulse registers
   always_ff @(posedge clock or negedge notReset) begin
      if (!notReset) begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            state_q[i] <= STABLE;
            count_q[i] <= '0;
         end
         debounced_q <= '0;
         press_q     <= '0;
         release_q   <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         debounced_q <= debounced_d;
         press_q     <= press_d;
         release_q   <= release_d;
      end
   end

   assign bus.debounced    = debounced_q;
   assign bus.pressPulse   = press_q;
   assign bus.releasePulse = release_q;

`ifdef BUTTON_DEBOUNCER_PRESS_LATCH_EN
   logic [NUM_INPUTS-1:0] latch_q, latch_d;

   // Sticky press flag; a press in the same cycle as a clear wins
   always_comb begin
      latch_d = press_q | (latch_q & ~bus.clearLatch);
   end

   // Press latch register
   always_ff @(posedge clock or negedge notReset) begin
      if (!notReset) begin
         latch_q <= '0;
      end else begin
         latch_q <= latch_d;
      end
   end

   assign bus.pressLatched = latch_q;
`endif

endmodule

`default_nettype wire

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Multi-channel input conditioner that sits directly upstream of the core's MMIO input port.
- Raw devboard button levels are asynchronous and bouncy. The block synchronises them to the core clock, debounces them, and presents clean levels plus one-cycle press/release pulses.
- Outputs drive the core's button input bits in place of the raw buttons.

Parameters:
- NUM_INPUTS, 4, number of independent channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new level (10 ms at 50 MHz). Must be >= 2.
- COUNTER_WIDTH, $clog2(DEBOUNCE_CYCLES), width of each per-channel stability counter.

Ports:
- clock  input  1  system clock, all state on rising edge.
- notReset  input  1  asynchronous active-low reset.
- rawButton  input  NUM_INPUTS  active-high raw button levels, asynchronous to clock.
- debounced  output  NUM_INPUTS  clean, registered button levels.
- pressPulse  output  NUM_INPUTS  one-cycle high when the debounced level goes 0->1.
- releasePulse  output  NUM_INPUTS  one-cycle high when the debounced level goes 1->0.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (notReset low clears all state immediately, independent of clock). While notReset is low:
  - sync flops, counters, debounced, pressPulse and releasePulse are all 0.
  - per-channel FSM is in STABLE.
- Synchroniser: per channel, two-flop chain sync1 <= rawButton, sync2 <= sync1. Only sync2 is used downstream.
- Per-channel FSM, two states:
  - STABLE: sync2 == debounced; counter held at 0. When sync2 != debounced: counter <= 1, go to VERIFY.
  - VERIFY, sync2 == debounced (bounce back): counter <= 0, go to STABLE. No output change.
  - VERIFY, sync2 != debounced, counter < DEBOUNCE_CYCLES-1: counter <= counter + 1.
  - VERIFY, sync2 != debounced, counter == DEBOUNCE_CYCLES-1: debounced <= sync2, counter <= 0, go to STABLE.
- Pulses:
  - Registered; asserted for exactly the one cycle after the edge on which debounced changes.
  - pressPulse for 0->1, releasePulse for 1->0.
  - Never both high on the same channel in the same cycle.
- Latency: take the edge at which sync1 first captures a new, thereafter-stable raw level as edge 0. debounced (and its pulse) updates at edge DEBOUNCE_CYCLES+1.
- Glitch rejection: any return to the old level before acceptance discards all progress. The counter restarts from 1 on the next disagreement.
- Channels are fully independent. Simultaneous transitions on several channels are each handled on their own schedule.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Reset asserted mid-VERIFY: progress is discarded and no pulse is generated. After release, a held-high raw input is accepted as a press again after the full latency.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_PRESS_LATCH_EN.
- Defined:
  - Adds input clearLatch (NUM_INPUTS) and output pressLatched (NUM_INPUTS), reset 0.
  - pressLatched[i] sets on the cycle pressPulse[i] is high and stays set until clearLatch[i] is sampled high.
  - If set and clear occur in the same cycle, set wins, so no press is lost.
  - This lets slow software polling catch short presses.
- Undefined: neither port exists and there is no latch logic. All other behaviour is identical.

Test Plan (DEBOUNCE_CYCLES=4, NUM_INPUTS=4):
- Clean press: rawButton 0000->0001, held -> debounced[0] rises at edge 5; pressPulse = 0001 for exactly one cycle; no other bits change.
- Bounce rejection: rawButton[1] high 3 cycles, low 1 cycle, high 3 cycles, then low -> debounced stays 0000; no pulses.
- Release: with debounced=0100, rawButton[2] 1->0, held -> debounced=0000 at edge 5; releasePulse = 0100 for one cycle; pressPulse stays 0.
- Simultaneous channels: rawButton 0000->1001 on one edge -> debounced goes 1001 on the same cycle; pressPulse = 1001 for one cycle.
- Async reset mid-count: raise rawButton[3], pull notReset low at edge 3 with no clock dependency -> all outputs 0 immediately. Release reset with raw still high -> debounced[3] rises 5 edges after sync1 recaptures; exactly one pressPulse.
- Latch (macro defined): press then release bit 0 -> pressLatched = 0001 persists. clearLatch=0001 -> pressLatched = 0000 next cycle. clearLatch coincident with pressPulse -> pressLatched stays 1.
